ex_stage: RTL and testbench

Execute stage plus EX/MEM pipeline register for the 5-stage MIPS core. It consumes the fields launched by the ID/EX register and resolves operand forwarding from its own EX/MEM outputs and from the MEM/WB writeback. It then runs the ALU and registers the result, store data, destination register and memory/writeback controls for the MEM stage. Load-use hazards are not handled here; the ID-stage hazard unit inserts a bubble upstream.

---
 rtl/ex_stage_if.sv | 44 ++++
 rtl/ex_stage.sv | 106 ++++++++++
 tb/tb_ex_stage.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// EX-stage bundle: ID/EX fields, MEM/WB writeback feedback and the EX/MEM register outputs.
// The ID/EX side drives through master; ex_stage consumes through slave.
interface ex_stage_if;
  logic        flush;
  logic        stall;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        Regdst;
  logic        MemRead;
  logic        MemtoReg;
  logic        MemWrite;
  logic        ALUsrc;
  logic        RegWrite;
  logic [1:0]  ALUOp;
  logic [31:0] Immediate;
  logic [31:0] read1;
  logic [31:0] read2;
  logic        wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest;
  logic        zero;
  logic        MemReadout;
  logic        MemWriteout;
  logic        MemtoRegout;
  logic        RegWriteout;

  modport master (
    output flush, stall, rs, rt, rd, Regdst, MemRead, MemtoReg, MemWrite, ALUsrc,
           RegWrite, ALUOp, Immediate, read1, read2, wb_RegWrite, wb_rd, wb_data,
    input  alu_result, store_data, dest, zero, MemReadout, MemWriteout, MemtoRegout,
           RegWriteout
  );

  modport slave (
    input  flush, stall, rs, rt, rd, Regdst, MemRead, MemtoReg, MemWrite, ALUsrc,
           RegWrite, ALUOp, Immediate, read1, read2, wb_RegWrite, wb_rd, wb_data,
    output alu_result, store_data, dest, zero, MemReadout, MemWriteout, MemtoRegout,
           RegWriteout
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, and the EX/MEM pipeline register.
// Every output is registered; forwarding reads the EX/MEM registers themselves.
module ex_stage (
  input logic      clk,
  input logic      reset,
  ex_stage_if.slave bus
);
  logic [31:0] alu_result_reg;
  logic [31:0] store_data_reg;
  logic [4:0]  dest_reg;
  logic        zero_reg;
  logic        mem_read_reg;
  logic        mem_write_reg;
  logic        mem_to_reg_reg;
  logic        reg_write_reg;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] alu_b;
  logic [31:0] alu_next;
  logic [4:0]  dest_next;
  logic [5:0]  funct;
  logic [4:0]  shamt;

  assign funct = bus.Immediate[5:0];
  assign shamt = bus.Immediate[10:6];

  // EX/MEM outranks MEM/WB because it holds the younger result; r0 never forwards.
  always_comb begin
    fwd_a = bus.read1;
    if (reg_write_reg && (dest_reg != 5'd0) && (dest_reg == bus.rs))
      fwd_a = alu_result_reg;
    else if (bus.wb_RegWrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rs))
      fwd_a = bus.wb_data;

    fwd_b = bus.read2;
    if (reg_write_reg && (dest_reg != 5'd0) && (dest_reg == bus.rt))
      fwd_b = alu_result_reg;
    else if (bus.wb_RegWrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rt))
      fwd_b = bus.wb_data;
  end

  assign alu_b     = bus.ALUsrc ? bus.Immediate : fwd_b;
  assign dest_next = bus.Regdst ? bus.rd : bus.rt;

  always_comb begin
    alu_next = 32'd0;
    case (bus.ALUOp)
      2'b00: alu_next = fwd_a + alu_b;
      2'b01: alu_next = fwd_a - alu_b;
      2'b11: alu_next = {31'd0, ($signed(fwd_a) < $signed(alu_b))};
      default: begin
        case (funct)
          6'b100000: alu_next = fwd_a + alu_b;
          6'b100010: alu_next = fwd_a - alu_b;
          6'b100100: alu_next = fwd_a & alu_b;
          6'b100101: alu_next = fwd_a | alu_b;
          6'b101010: alu_next = {31'd0, ($signed(fwd_a) < $signed(alu_b))};
          6'b000000: alu_next = alu_b << shamt;
          default:   alu_next = 32'd0;
        endcase
      end
    endcase
  end

  // Flush outranks stall so a bubble still gets inserted while the pipe is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_reg <= 32'd0;
      store_data_reg <= 32'd0;
      dest_reg       <= 5'd0;
      zero_reg       <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      reg_write_reg  <= 1'b0;
    end else if (bus.flush) begin
      alu_result_reg <= alu_next;
      store_data_reg <= fwd_b;
      dest_reg       <= dest_next;
      zero_reg       <= (alu_next == 32'd0);
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      reg_write_reg  <= 1'b0;
    end else if (!bus.stall) begin
      alu_result_reg <= alu_next;
      store_data_reg <= fwd_b;
      dest_reg       <= dest_next;
      zero_reg       <= (alu_next == 32'd0);
      mem_read_reg   <= bus.MemRead;
      mem_write_reg  <= bus.MemWrite;
      mem_to_reg_reg <= bus.MemtoReg;
      reg_write_reg  <= bus.RegWrite;
    end
  end

  assign bus.alu_result  = alu_result_reg;
  assign bus.store_data  = store_data_reg;
  assign bus.dest        = dest_reg;
  assign bus.zero        = zero_reg;
  assign bus.MemReadout  = mem_read_reg;
  assign bus.MemWriteout = mem_write_reg;
  assign bus.MemtoRegout = mem_to_reg_reg;
  assign bus.RegWriteout = reg_write_reg;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, forwarding priority, r0 guard, store path,
// flush/stall interaction and ALU corner cases, all against hand-computed values.
module tb_ex_stage;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cycle;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.flush = 1'b0;       bus.stall = 1'b0;
    bus.rs = 5'd0;          bus.rt = 5'd0;        bus.rd = 5'd0;
    bus.Regdst = 1'b0;      bus.MemRead = 1'b0;   bus.MemtoReg = 1'b0;
    bus.MemWrite = 1'b0;    bus.ALUsrc = 1'b0;    bus.RegWrite = 1'b0;
    bus.ALUOp = 2'b00;      bus.Immediate = 32'd0;
    bus.read1 = 32'd0;      bus.read2 = 32'd0;
    bus.wb_RegWrite = 1'b0; bus.wb_rd = 5'd0;     bus.wb_data = 32'd0;
  endtask

  // Advance one edge and sample 1 time unit later, away from the edge.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    cycle++;
    $display("cycle %0d %s: alu=%h sd=%h dest=%0d z=%b mr=%b mw=%b m2r=%b rw=%b", cycle, tag,
             bus.alu_result, bus.store_data, bus.dest, bus.zero, bus.MemReadout,
             bus.MemWriteout, bus.MemtoRegout, bus.RegWriteout);
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.rs = 5'd7; bus.rt = 5'd9; bus.rd = 5'd11; bus.Regdst = 1'b1;
    bus.MemRead = 1'b1; bus.MemtoReg = 1'b1; bus.MemWrite = 1'b1; bus.RegWrite = 1'b1;
    bus.read1 = 32'hAAAA5555; bus.read2 = 32'h12345678; bus.ALUOp = 2'b00;
    reset = 1'b1;
    step("reset");
    step("reset");
    total++;
    if (bus.alu_result !== 32'd0 || bus.store_data !== 32'd0 || bus.dest !== 5'd0) begin
      bad++;
      $display("FAIL reset_data got alu=%h sd=%h dest=%0d want 0 0 0",
               bus.alu_result, bus.store_data, bus.dest);
    end
    total++;
    if ({bus.zero, bus.MemReadout, bus.MemWriteout, bus.MemtoRegout, bus.RegWriteout} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got z/mr/mw/m2r/rw=%b want 00000",
               {bus.zero, bus.MemReadout, bus.MemWriteout, bus.MemtoRegout, bus.RegWriteout});
    end
    reset = 1'b0;
    // add r3 = r1 + r2
    idle_inputs();
    bus.rs = 5'd1; bus.rt = 5'd2; bus.rd = 5'd3; bus.Regdst = 1'b1; bus.RegWrite = 1'b1;
    bus.ALUOp = 2'b10; bus.Immediate = 32'h00000020; bus.read1 = 32'd5; bus.read2 = 32'd7;
    step("add r3");
    total++;
    if (bus.alu_result !== 32'd12 || bus.dest !== 5'd3) begin
      bad++;
      $display("FAIL first_add got alu=%0d dest=%0d want 12 3", bus.alu_result, bus.dest);
    end
    total++;
    if (bus.RegWriteout !== 1'b1 || bus.zero !== 1'b0) begin
      bad++;
      $display("FAIL first_add_ctrl got rw=%b z=%b want 1 0", bus.RegWriteout, bus.zero);
    end
  endtask

  task automatic test_forward();
    // sub r4 = r3 - r1: r3 in EX/MEM (12) must beat MEM/WB (50)
    idle_inputs();
    bus.rs = 5'd3; bus.rt = 5'd1; bus.rd = 5'd4; bus.Regdst = 1'b1; bus.RegWrite = 1'b1;
    bus.ALUOp = 2'b10; bus.Immediate = 32'h00000022; bus.read1 = 32'd99; bus.read2 = 32'd5;
    bus.wb_RegWrite = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'd50;
    step("sub exmem");
    total++;
    if (bus.alu_result !== 32'd7) begin
      bad++;
      $display("FAIL fwd_exmem_priority got %0d want 7", bus.alu_result);
    end
    // place a non-writing instruction with dest=3 in EX/MEM
    idle_inputs();
    bus.rs = 5'd1; bus.rt = 5'd2; bus.rd = 5'd3; bus.Regdst = 1'b1;
    bus.read1 = 32'd1; bus.read2 = 32'd1;
    step("nowrite r3");
    total++;
    if (bus.RegWriteout !== 1'b0 || bus.dest !== 5'd3 || bus.alu_result !== 32'd2) begin
      bad++;
      $display("FAIL nowrite got rw=%b dest=%0d alu=%0d want 0 3 2",
               bus.RegWriteout, bus.dest, bus.alu_result);
    end
    idle_inputs();
    bus.rs = 5'd3; bus.rt = 5'd1; bus.rd = 5'd4; bus.Regdst = 1'b1; bus.RegWrite = 1'b1;
    bus.ALUOp = 2'b10; bus.Immediate = 32'h00000022; bus.read1 = 32'd99; bus.read2 = 32'd5;
    bus.wb_RegWrite = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'd50;
    step("sub memwb");
    total++;
    if (bus.alu_result !== 32'd45) begin
      bad++;
      $display("FAIL fwd_memwb got %0d want 45", bus.alu_result);
    end
  endtask

  task automatic test_r0_guard();
    idle_inputs();
    bus.rs = 5'd5; bus.rt = 5'd6; bus.rd = 5'd0; bus.Regdst = 1'b1; bus.RegWrite = 1'b1;
    bus.read1 = 32'd10; bus.read2 = 32'd20;
    step("write r0");
    total++;
    if (bus.dest !== 5'd0 || bus.RegWriteout !== 1'b1 || bus.alu_result !== 32'd30) begin
      bad++;
      $display("FAIL r0_setup got dest=%0d rw=%b alu=%0d want 0 1 30",
               bus.dest, bus.RegWriteout, bus.alu_result);
    end
    idle_inputs();
    bus.rs = 5'd0; bus.rt = 5'd7; bus.rd = 5'd8; bus.Regdst = 1'b1;
    bus.wb_RegWrite = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'd9;
    step("read r0");
    total++;
    if (bus.alu_result !== 32'd0 || bus.zero !== 1'b1) begin
      bad++;
      $display("FAIL r0_guard got alu=%0d z=%b want 0 1", bus.alu_result, bus.zero);
    end
  endtask

  task automatic test_store();
    idle_inputs();
    bus.rs = 5'd8; bus.rt = 5'd9; bus.ALUOp = 2'b00; bus.ALUsrc = 1'b1; bus.MemWrite = 1'b1;
    bus.Immediate = 32'hFFFFFFFC; bus.read1 = 32'h00000100; bus.read2 = 32'h00001111;
    bus.wb_RegWrite = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'hDEADBEEF;
    step("sw");
    total++;
    if (bus.alu_result !== 32'h000000FC || bus.store_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL store_data got alu=%h sd=%h want 000000fc deadbeef",
               bus.alu_result, bus.store_data);
    end
    total++;
    if (bus.MemWriteout !== 1'b1 || bus.RegWriteout !== 1'b0 || bus.dest !== 5'd9) begin
      bad++;
      $display("FAIL store_ctrl got mw=%b rw=%b dest=%0d want 1 0 9",
               bus.MemWriteout, bus.RegWriteout, bus.dest);
    end
  endtask

  task automatic load_other_add();
    idle_inputs();
    bus.rs = 5'd10; bus.rt = 5'd11; bus.ALUOp = 2'b00; bus.read1 = 32'd1; bus.read2 = 32'd2;
    bus.MemRead = 1'b1; bus.MemtoReg = 1'b1; bus.MemWrite = 1'b1; bus.RegWrite = 1'b1;
  endtask

  task automatic test_flush_stall();
    load_other_add();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      total++;
      if (bus.alu_result !== 32'h000000FC || bus.store_data !== 32'hDEADBEEF || bus.dest !== 5'd9 ||
          bus.MemWriteout !== 1'b1 || bus.MemReadout !== 1'b0 || bus.RegWriteout !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d] got alu=%h sd=%h dest=%0d mw=%b mr=%b rw=%b want fc deadbeef 9 1 0 0",
                 i, bus.alu_result, bus.store_data, bus.dest, bus.MemWriteout, bus.MemReadout,
                 bus.RegWriteout);
      end
    end
    load_other_add();
    bus.stall = 1'b1; bus.flush = 1'b1;
    step("flush+stall");
    total++;
    if ({bus.MemReadout, bus.MemWriteout, bus.MemtoRegout, bus.RegWriteout} !== 4'b0000) begin
      bad++;
      $display("FAIL flush_ctrl got mr/mw/m2r/rw=%b want 0000",
               {bus.MemReadout, bus.MemWriteout, bus.MemtoRegout, bus.RegWriteout});
    end
    total++;
    if (bus.alu_result !== 32'd3 || bus.dest !== 5'd11 || bus.store_data !== 32'd2) begin
      bad++;
      $display("FAIL flush_data got alu=%0d dest=%0d sd=%0d want 3 11 2",
               bus.alu_result, bus.dest, bus.store_data);
    end
    // beq reads rt=11, matching the bubble's dest; the bubble must not forward
    idle_inputs();
    bus.rs = 5'd4; bus.rt = 5'd11; bus.ALUOp = 2'b01; bus.read1 = 32'd4; bus.read2 = 32'd4;
    step("beq");
    total++;
    if (bus.zero !== 1'b1 || bus.alu_result !== 32'd0) begin
      bad++;
      $display("FAIL beq_zero got z=%b alu=%h want 1 0", bus.zero, bus.alu_result);
    end
  endtask

  task automatic test_alu_corners();
    logic [1:0]  op_t  [9];
    logic        src_t [9];
    logic [31:0] imm_t [9];
    logic [31:0] a_t   [9];
    logic [31:0] b_t   [9];
    logic [31:0] exp_t [9];
    op_t  = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11};
    src_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    imm_t = '{32'h2A, 32'h7C0, 32'h0, 32'h3F, 32'hFFFFFFFF, 32'h24, 32'h25, 32'h22, 32'h5};
    a_t   = '{32'hFFFFFFFF, 32'h1234, 32'h7FFFFFFF, 32'd5, 32'd0, 32'hF0F0, 32'hF0F0, 32'd3,
              32'hFFFFFFFB};
    b_t   = '{32'd1, 32'd1, 32'd1, 32'd3, 32'd0, 32'hFF00, 32'hFF00, 32'd5, 32'd0};
    exp_t = '{32'd1, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'hF000, 32'hFFF0,
              32'hFFFFFFFE, 32'd1};
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      bus.rs = 5'd12; bus.rt = 5'd13; bus.rd = 5'd14; bus.Regdst = 1'b1;
      bus.ALUOp = op_t[i]; bus.ALUsrc = src_t[i]; bus.Immediate = imm_t[i];
      bus.read1 = a_t[i]; bus.read2 = b_t[i];
      step("alu");
      total++;
      if (bus.alu_result !== exp_t[i] || bus.zero !== (exp_t[i] == 32'd0)) begin
        bad++;
        $display("FAIL alu_corner[%0d] got alu=%h z=%b want %h %b",
                 i, bus.alu_result, bus.zero, exp_t[i], (exp_t[i] == 32'd0));
      end
    end
  endtask

  task automatic test_reset_midstream();
    load_other_add();
    step("pre-reset add");
    total++;
    if (bus.alu_result !== 32'd3 || bus.MemReadout !== 1'b1 || bus.RegWriteout !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got alu=%0d mr=%b rw=%b want 3 1 1",
               bus.alu_result, bus.MemReadout, bus.RegWriteout);
    end
    reset = 1'b1;
    step("mid reset");
    total++;
    if (bus.alu_result !== 32'd0 || bus.dest !== 5'd0 ||
        {bus.MemReadout, bus.MemWriteout, bus.MemtoRegout, bus.RegWriteout} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset got alu=%h dest=%0d ctrl=%b want 0 0 0000", bus.alu_result, bus.dest,
               {bus.MemReadout, bus.MemWriteout, bus.MemtoRegout, bus.RegWriteout});
    end
    reset = 1'b0;
    step("post-reset add");
    total++;
    if (bus.alu_result !== 32'd3 || bus.dest !== 5'd11 || bus.MemWriteout !== 1'b1) begin
      bad++;
      $display("FAIL post_reset got alu=%0d dest=%0d mw=%b want 3 11 1",
               bus.alu_result, bus.dest, bus.MemWriteout);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cycle = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_forward();
    test_r0_guard();
    test_store();
    test_flush_stall();
    test_alu_corners();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
